rom_dl_sender: RTL

ROM_DL_SENDER -- requirements
Module: rom_dl_sender

---
 rtl/rom_dl_sender.sv | 137 +++++++++++++
 1 files changed

// File: rtl/rom_dl_sender.sv
// Streams IMG_LEN bytes from a valid/ready source into a core's ROM download
// port, one ROMEN strobe per byte, with timeout and abort handling.
module rom_dl_sender #(
    parameter int IMG_LEN    = 163840,
    parameter int STROBE_LEN = 2,
    parameter int GAP_LEN    = 1,
    parameter int TIMEOUT    = 65535
) (
    input  logic        clk48M,
    input  logic        reset_n,
    input  logic        START,
    input  logic        ABORT,
    input  logic [7:0]  IN_DT,
    input  logic        IN_VLD,
    output logic        IN_RDY,
    output logic [17:0] ROMAD,
    output logic [7:0]  ROMDT,
    output logic        ROMEN,
    output logic        BUSY,
    output logic        DONE,
    output logic        ERR
);

    localparam int PHASE_MAX = (STROBE_LEN > GAP_LEN) ? STROBE_LEN : GAP_LEN;
    localparam int PW        = $clog2(PHASE_MAX + 1);
    localparam int TW        = $clog2(TIMEOUT + 1);

    localparam logic [17:0]   LAST_ADDR   = 18'(IMG_LEN - 1);
    localparam logic [PW-1:0] STROBE_LAST = PW'(STROBE_LEN - 1);
    localparam logic [PW-1:0] GAP_LAST    = PW'(GAP_LEN - 1);
    localparam logic [TW-1:0] IDLE_LAST   = TW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        STROBE,
        GAP,
        FIN
    } state_t;

    state_t        state;
    logic [17:0]   addr;
    logic [PW-1:0] phase_cnt;
    logic [TW-1:0] idle_cnt;

    // IN_RDY, BUSY and DONE are set on the edge entering a state so each
    // registered output already matches the state it describes.
    always_ff @(posedge clk48M or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            addr      <= '0;
            phase_cnt <= '0;
            idle_cnt  <= '0;
            IN_RDY    <= 1'b0;
            ROMAD     <= '0;
            ROMDT     <= '0;
            ROMEN     <= 1'b0;
            BUSY      <= 1'b0;
            DONE      <= 1'b0;
            ERR       <= 1'b0;
        end else if (ABORT && state != IDLE) begin
            state     <= IDLE;
            phase_cnt <= '0;
            idle_cnt  <= '0;
            IN_RDY    <= 1'b0;
            ROMEN     <= 1'b0;
            BUSY      <= 1'b0;
            DONE      <= 1'b0;
            ERR       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (START && !ABORT) begin
                        addr      <= '0;
                        phase_cnt <= '0;
                        idle_cnt  <= '0;
                        DONE      <= 1'b0;
                        ERR       <= 1'b0;
                        BUSY      <= 1'b1;
                        IN_RDY    <= 1'b1;
                        state     <= FETCH;
                    end
                end
                FETCH: begin
                    if (IN_VLD && IN_RDY) begin
                        ROMDT     <= IN_DT;
                        ROMAD     <= addr;
                        ROMEN     <= 1'b1;
                        IN_RDY    <= 1'b0;
                        phase_cnt <= '0;
                        state     <= STROBE;
                    end else if (idle_cnt == IDLE_LAST) begin
                        ERR    <= 1'b1;
                        BUSY   <= 1'b0;
                        IN_RDY <= 1'b0;
                        state  <= IDLE;
                    end else begin
                        idle_cnt <= idle_cnt + 1'b1;
                    end
                end
                STROBE: begin
                    if (phase_cnt == STROBE_LAST) begin
                        ROMEN     <= 1'b0;
                        phase_cnt <= '0;
                        state     <= GAP;
                    end else begin
                        phase_cnt <= phase_cnt + 1'b1;
                    end
                end
                GAP: begin
                    if (phase_cnt == GAP_LAST) begin
                        phase_cnt <= '0;
                        if (addr == LAST_ADDR) begin
                            BUSY  <= 1'b0;
                            DONE  <= 1'b1;
                            state <= FIN;
                        end else begin
                            addr     <= addr + 18'd1;
                            idle_cnt <= '0;
                            IN_RDY   <= 1'b1;
                            state    <= FETCH;
                        end
                    end else begin
                        phase_cnt <= phase_cnt + 1'b1;
                    end
                end
                FIN: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
